// File: rtl/data_memory_pkg.sv
// Shared definitions for the stage-4 data memory: data typedefs and load_type encodings.
package data_memory_pkg;

    typedef logic [31:0] word;
    typedef logic [15:0] hword;

    localparam logic [2:0] byte_mask  = 3'b001;
    localparam logic [2:0] hword_mask = 3'b010;
    localparam logic [2:0] word_mask  = 3'b100;

    // Right-aligned extension of a byte or halfword to 32 bits.
    function automatic word extend(input hword val, input logic is_half, input logic sext);
        logic msb;
        msb = is_half ? val[15] : val[7];
        if (is_half)
            return {{16{sext & msb}}, val};
        else
            return {{24{sext & msb}}, val[7:0]};
    endfunction

endpackage

// File: rtl/data_memory_if.sv
// Load/store bus between the memory stage and the data memory.
interface data_memory_if;
    import data_memory_pkg::*;

    logic       read;
    logic       write;
    logic       sign_extend;
    logic [2:0] load_type;
    word        long_addr;
    word        write_value;
    word        read_value;

    modport master (
        output read, write, sign_extend, load_type, long_addr, write_value,
        input  read_value
    );

    modport slave (
        input  read, write, sign_extend, load_type, long_addr, write_value,
        output read_value
    );

endinterface

// File: rtl/data_memory_ram.sv
// DEPTH_WORDS x 32 storage with per-byte write enables and a registered, read-first read port.
module data_memory_ram
    import data_memory_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clock,
    input  logic [AW-1:0] i_addr,
    input  logic [3:0]    i_we,
    input  word           i_wdata,
    input  logic          i_re,
    output word           o_rdata
);

    word r_mem [DEPTH_WORDS];
    word r_rdata;

    // Nonblocking read and write on the same edge give read-first behaviour.
    always_ff @(posedge clock) begin
        for (int l = 0; l < 4; l++) begin
            if (i_we[l])
                r_mem[i_addr][l*8 +: 8] <= i_wdata[l*8 +: 8];
        end
        if (i_re)
            r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_memory_top.sv
// Byte-addressable little-endian data memory: lane decode, store replication,
// load lane select/extension, 1-cycle registered load result.
module data_memory_top
    import data_memory_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic          clock,
    input  logic          reset,
    data_memory_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [AW-1:0] w_index;
    logic [1:0]    w_lane;
    logic [3:0]    w_be;
    logic [3:0]    w_we;
    word           w_wdata;
    logic          w_re;
    word           w_rdata;
    hword          w_half;
    logic          w_unused_addr;

    logic          r_valid;
    logic [1:0]    r_lane;
    logic [2:0]    r_type;
    logic          r_sext;

    assign w_index       = bus.long_addr[AW+1:2];
    assign w_lane        = bus.long_addr[1:0];
    assign w_unused_addr = ^bus.long_addr[31:AW+2];

    // Alignment is forced: hword drops addr[0], word drops addr[1:0].
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = bus.write_value;
        case (bus.load_type)
            byte_mask: begin
                w_be    = 4'b0001 << w_lane;
                w_wdata = {4{bus.write_value[7:0]}};
            end
            hword_mask: begin
                w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{bus.write_value[15:0]}};
            end
            word_mask: w_be = 4'b1111;
            default:   w_be = 4'b0000;
        endcase
    end

    assign w_we = (bus.write && !reset) ? w_be : 4'b0000;
    assign w_re = bus.read && !reset;

    data_memory_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clock   (clock),
        .i_addr  (w_index),
        .i_we    (w_we),
        .i_wdata (w_wdata),
        .i_re    (w_re),
        .o_rdata (w_rdata)
    );

    // Load attributes travel alongside the RAM read; clearing r_valid zeroes read_value at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_lane  <= 2'b00;
            r_type  <= 3'b000;
            r_sext  <= 1'b0;
        end else if (bus.read) begin
            r_valid <= 1'b1;
            r_lane  <= w_lane;
            r_type  <= bus.load_type;
            r_sext  <= bus.sign_extend;
        end
    end

    assign w_half = r_lane[1] ? w_rdata[31:16] : w_rdata[15:0];

    always_comb begin
        bus.read_value = '0;
        if (r_valid) begin
            case (r_type)
                byte_mask:  bus.read_value = extend({8'h00, w_rdata[{r_lane, 3'b000} +: 8]}, 1'b0, r_sext);
                hword_mask: bus.read_value = extend(w_half, 1'b1, r_sext);
                word_mask:  bus.read_value = w_rdata;
                default:    bus.read_value = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_top.sv
// Self-checking bench for data_memory_top: directed test plan plus random traffic against a byte-array model.
module tb_data_memory_top;
    import data_memory_pkg::*;

    localparam int D  = 64;
    localparam int NB = 4 * D;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    data_memory_if bus();

    data_memory_top #(.DEPTH_WORDS(D)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] mem [NB];
    word        last;
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string tag, input word got, input word exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic word mload(input word a, input logic [2:0] lt, input logic sx);
        int unsigned i;
        logic [7:0]  b;
        logic [15:0] h;
        i = a % NB;
        case (lt)
            byte_mask: begin
                b = mem[i];
                return sx ? {{24{b[7]}}, b} : {24'h0, b};
            end
            hword_mask: begin
                i = i - i % 2;
                h = {mem[i+1], mem[i]};
                return sx ? {{16{h[15]}}, h} : {16'h0, h};
            end
            word_mask: begin
                i = i - i % 4;
                return {mem[i+3], mem[i+2], mem[i+1], mem[i]};
            end
            default: return 32'h0;
        endcase
    endfunction

    task automatic mstore(input word a, input logic [2:0] lt, input word v);
        int unsigned i;
        i = a % NB;
        case (lt)
            byte_mask: mem[i] = v[7:0];
            hword_mask: begin
                i = i - i % 2;
                mem[i]   = v[7:0];
                mem[i+1] = v[15:8];
            end
            word_mask: begin
                i = i - i % 4;
                for (int k = 0; k < 4; k++) mem[i+k] = v[k*8 +: 8];
            end
            default: ;
        endcase
    endtask

    // Called at a falling edge; checks read_value at the next falling edge.
    task automatic do_op(input string tag, input logic rd, input logic wr, input logic sx,
                         input logic [2:0] lt, input word a, input word v,
                         input logic use_exp, input word exp);
        bus.read        = rd;
        bus.write       = wr;
        bus.sign_extend = sx;
        bus.load_type   = lt;
        bus.long_addr   = a;
        bus.write_value = v;
        if (rd) last = use_exp ? exp : mload(a, lt, sx);
        if (wr) mstore(a, lt, v);
        @(negedge clock);
        check(tag, bus.read_value, last);
        bus.read  = 1'b0;
        bus.write = 1'b0;
    endtask

    word bl_exp [7] = '{32'hFE, 32'h0, 32'h0, 32'h04, 32'h0, 32'h0, 32'hF8};
    word bs_exp [7] = '{32'hFFFFFFFE, 32'h0, 32'h0, 32'h04, 32'h0, 32'h0, 32'hFFFFFFF8};
    word hl_exp [7] = '{32'hF830, 32'h0400, 32'h0, 32'h0FA0, 32'h1000, 32'h0, 32'hE0C0};
    word hs_exp [7] = '{32'hFFFFF830, 32'h0400, 32'h0, 32'h0FA0, 32'h1000, 32'h0, 32'hFFFFE0C0};
    word bst_a  [4] = '{32'd0, 32'd3, 32'd6, 32'd9};
    word bst_v  [4] = '{32'hFE, 32'h04, 32'hF8, 32'h10};
    word hst_a  [4] = '{32'd0, 32'd6, 32'd12, 32'd18};
    word hst_v  [4] = '{32'hF830, 32'h0FA0, 32'hE0C0, 32'h3E80};

    initial begin
        logic [2:0] lt;
        reset = 1'b1;
        bus.read = 1'b0; bus.write = 1'b0; bus.sign_extend = 1'b0;
        bus.load_type = word_mask; bus.long_addr = '0; bus.write_value = '0;
        last = '0;
        repeat (2) @(negedge clock);
        check("reset_state", bus.read_value, 32'h0);
        reset = 1'b0;

        for (int w = 0; w < D; w++) do_op("clear", 0, 1, 0, word_mask, word'(w * 4), 32'h0, 0, 32'h0);

        for (int k = 0; k < 4; k++) do_op("sb", 0, 1, 0, byte_mask, bst_a[k], bst_v[k], 0, 32'h0);
        for (int k = 0; k < 7; k++) do_op("lbu", 1, 0, 0, byte_mask, word'(k), 32'h0, 1, bl_exp[k]);
        for (int k = 0; k < 7; k++) do_op("lb", 1, 0, 1, byte_mask, word'(k), 32'h0, 1, bs_exp[k]);

        for (int k = 0; k < 4; k++) do_op("sh", 0, 1, 0, hword_mask, hst_a[k], hst_v[k], 0, 32'h0);
        for (int k = 0; k < 7; k++) do_op("lhu", 1, 0, 0, hword_mask, word'(2 * k), 32'h0, 1, hl_exp[k]);
        for (int k = 0; k < 7; k++) do_op("lh", 1, 0, 1, hword_mask, word'(2 * k), 32'h0, 1, hs_exp[k]);

        do_op("sw16", 0, 1, 0, word_mask, 32'd16, 32'h12345678, 0, 32'h0);
        do_op("lw19", 1, 0, 0, word_mask, 32'd19, 32'h0, 1, 32'h12345678);
        do_op("lhu17", 1, 0, 0, hword_mask, 32'd17, 32'h0, 1, 32'h00005678);
        do_op("lbu18", 1, 0, 1, byte_mask, 32'd18, 32'h0, 1, 32'h00000034);
        do_op("hold", 0, 0, 0, word_mask, 32'd0, 32'h0, 0, 32'h0);
        do_op("bad_type_ld", 1, 0, 0, 3'b011, 32'd16, 32'h0, 1, 32'h0);
        do_op("bad_type_st", 0, 1, 0, 3'b111, 32'd16, 32'hFFFFFFFF, 0, 32'h0);
        do_op("bad_st_kept", 1, 0, 0, word_mask, 32'd16, 32'h0, 1, 32'h12345678);

        // Mid-stream reset: result cleared at once; a store requested during reset is dropped.
        #2 reset = 1'b1;
        #1 check("reset_async", bus.read_value, 32'h0);
        last = 32'h0;
        bus.read = 1'b1; bus.write = 1'b1; bus.load_type = word_mask;
        bus.long_addr = 32'd16; bus.write_value = 32'hDEADBEEF;
        @(negedge clock);
        check("reset_hold", bus.read_value, 32'h0);
        bus.read = 1'b0; bus.write = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        check("reset_release", bus.read_value, 32'h0);
        do_op("after_reset", 1, 0, 0, word_mask, 32'd16, 32'h0, 1, 32'h12345678);
        do_op("wrap_addr", 1, 0, 0, word_mask, 32'h8000_0000 + NB + 16, 32'h0, 1, 32'h12345678);

        do_op("rw_old", 1, 1, 0, word_mask, 32'd16, 32'hCAFEF00D, 1, 32'h12345678);
        do_op("rw_new", 1, 0, 0, word_mask, 32'd16, 32'h0, 1, 32'hCAFEF00D);

        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: lt = byte_mask;
                3, 4, 5: lt = hword_mask;
                6, 7, 8: lt = word_mask;
                default: lt = 3'($urandom_range(0, 7));
            endcase
            do_op("rand", 1'($urandom), 1'($urandom), 1'($urandom), lt, $urandom, $urandom, 0, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
